wb_port_arbiter: RTL

- Shares the single register-file write port behind the write-back stage between NUM_REQ producers: ALU pipe (0), load/MEM pipe (1) and multi-cycle MUL/DIV unit (2).
- Arbitration is round-robin with a valid/ready handshake; the winning write is registered onto the write port one cycle later.
- Drives a stall back to the pipeline while any producer waits, and keeps a saturating conflict counter for performance debug.

---
 rtl/wb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/wb_port_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back port arbiter.
package wb_pkg;

  // Default widths of the register-file write port.
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_W  = 5;

  // Fixed requester slots on the write-back port.
  localparam int unsigned REQ_ALU    = 0;
  localparam int unsigned REQ_MEM    = 1;
  localparam int unsigned REQ_MULDIV = 2;

  // One write request at the default widths.
  typedef struct packed {
    logic [DEF_REG_W-1:0]  rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan candidates in priority order starting at ptr; keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    if (enable) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        cand = IDX_W'((32'(ptr) + off) % NUM_REQ);
        if (!found && req[cand]) begin
          found       = 1'b1;
          grant_idx   = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin sharing of the single register-file write port between producers.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned REG_W   = DEF_REG_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      wb_enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*REG_W-1:0]  req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [REG_W-1:0]          wr_reg,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      stall_out,
  output logic [CNT_W-1:0]          conflict_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_W-1:0]  wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               xfer;
  logic [REG_W-1:0]   sel_reg;
  logic [DATA_W-1:0]  sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .enable    (wb_enable),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Transfer detection, payload mux, and next-state for pointer, write port, counter.
  always_comb begin
    xfer      = |(req_valid & grant);
    sel_reg   = req_reg[grant_idx*REG_W +: REG_W];
    sel_data  = req_data[grant_idx*DATA_W +: DATA_W];
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    if (xfer) begin
      rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      // Register 0 is hardwired: accept the request but never strobe the write.
      if (sel_reg != '0) begin
        wr_en_d   = 1'b1;
        wr_reg_d  = sel_reg;
        wr_data_d = sel_data;
      end
    end
    if (($countones(req_valid) >= 2) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; an in-flight write is dropped on reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready    = grant;
  assign stall_out    = |(req_valid & ~grant);
  assign wr_en        = wr_en_q;
  assign wr_reg       = wr_reg_q;
  assign wr_data      = wr_data_q;
  assign conflict_cnt = cnt_q;

endmodule
